// File: rtl/graph_col_buffer_pkg.sv
// graph_pkg: shared types and helpers for the graph column-height buffer.
//   gcb_state_t - fetch/swap controller states
//   flat_idx()  - (channel, column) -> flat element index
//   GCB_N_CH, GCB_N_COLS - default geometry; N_ELEM / IDX_W derive from it
package graph_pkg;

  localparam int GCB_N_CH   = 5;
  localparam int GCB_N_COLS = 20;
  localparam int N_ELEM     = GCB_N_CH * GCB_N_COLS;
  localparam int IDX_W      = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    WAIT_EOF
  } gcb_state_t;

  // Element (ch, col) sits at ch*n_cols + col in both the buffers and the
  // memory window starting at BASE_ADDR.
  function automatic int flat_idx(input int ch, input int col,
                                  input int n_cols = GCB_N_COLS);
    return ch * n_cols + col;
  endfunction

endpackage

// File: rtl/graph_col_buffer_if.sv
// graph_col_buffer_if: control, char-memory port 2 and active-buffer bundle.
//   slave  - the buffer: takes en/trg/eof/ch_mask/mem_din, drives
//            mem_addr/mem_rd/busy/swap_done/out
//   master - the driving side (sync/control logic, memory, interpolators)
interface graph_col_buffer_if
  import graph_pkg::*;
#(
  parameter int N_CH   = GCB_N_CH,
  parameter int N_COLS = GCB_N_COLS,
  parameter int D_W    = 8,
  parameter int A_W    = 13
);

  logic                       en;
  logic                       trg;
  logic                       eof;
  logic [N_CH-1:0]            ch_mask;
  logic [D_W-1:0]             mem_din;
  logic [A_W-1:0]             mem_addr;
  logic                       mem_rd;
  logic                       busy;
  logic                       swap_done;
  logic [N_CH*N_COLS*D_W-1:0] out;

  modport slave (
    input  en, trg, eof, ch_mask, mem_din,
    output mem_addr, mem_rd, busy, swap_done, out
  );

  modport master (
    output en, trg, eof, ch_mask, mem_din,
    input  mem_addr, mem_rd, busy, swap_done, out
  );

endinterface

// File: rtl/graph_col_buffer_rd_lat_pipe.sv
// rd_lat_pipe: carries {valid, element index} alongside a memory read so the
// returning data can be written to the right shadow slot LAT cycles later.
//   clk, rst - clock, synchronous active-high reset
//   en       - low flushes every in-flight valid bit
//   in_vld / in_idx   - issue-cycle tag
//   out_vld / out_idx - tag aligned with the read data
module rd_lat_pipe
  import graph_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int IDX_W = graph_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_vld,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_vld,
  output logic [IDX_W-1:0] out_idx
);

  logic [LAT-1:0]            vld;
  logic [LAT-1:0][IDX_W-1:0] idx;

  // NOTE: state registers use non-blocking assignments so every stage reads
  // the previous cycle's value of its neighbour, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      vld <= '0;
    end else begin
      vld[0] <= in_vld;
      for (int i = 1; i < LAT; i++) vld[i] <= vld[i-1];
    end
  end

  // NOTE: the index stages are not reset; they are only consumed when the
  // matching valid bit is set, so their power-up contents never matter.
  always_ff @(posedge clk) begin
    idx[0] <= in_idx;
    for (int i = 1; i < LAT; i++) idx[i] <= idx[i-1];
  end

  assign out_vld = vld[LAT-1];
  assign out_idx = idx[LAT-1];

endmodule

// File: rtl/graph_col_buffer.sv
// graph_col_buffer: double-buffered multi-channel column-height store.
// A trigger fetches the enabled channels from char-memory port 2 into a shadow
// buffer; the next end-of-frame pulse copies shadow to the active buffer so the
// line interpolators never see a half-updated graph.
//   clk  - CLOCK_50 domain system clock
//   rst  - synchronous active-high reset
//   bus  - graph_col_buffer_if.slave: en, trg, eof, ch_mask, mem_din in;
//          mem_addr, mem_rd, busy, swap_done, out (active buffer) out
module graph_col_buffer
  import graph_pkg::*;
#(
  parameter int             N_CH      = GCB_N_CH,
  parameter int             N_COLS    = GCB_N_COLS,
  parameter int             D_W       = 8,
  parameter int             A_W       = 13,
  parameter logic [A_W-1:0] BASE_ADDR = 13'h0800,
  parameter int             MEM_LAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  graph_col_buffer_if.slave  bus
);

  localparam int ELEMS = N_CH * N_COLS;
  localparam int IW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DC_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLS - 1);

  gcb_state_t               state, state_n;
  logic [N_CH-1:0]          mask_q, mask_n;
  logic [CH_W-1:0]          cur_ch, ch_n;
  logic [COL_W-1:0]         cur_col, col_n;
  logic [DC_W-1:0]          drain_cnt, drain_n;
  logic                     pending, pending_n;
  logic                     swap_done_q;
  logic                     issue, do_swap;
  logic [CH_W-1:0]          first_ch, nxt_ch;
  logic                     nxt_found;
  logic [IW-1:0]            issue_idx, cap_idx;
  logic                     cap_vld;
  logic [ELEMS-1:0][D_W-1:0] shadow, active;

  // Lowest channel of the incoming mask, and the next enabled channel above
  // the current one in the latched mask. Scanning downward leaves the lowest hit.
  always_comb begin
    first_ch  = '0;
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.ch_mask[i]) first_ch = CH_W'(i);
      if (mask_q[i] && (CH_W'(i) > cur_ch)) begin
        nxt_ch    = CH_W'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets its default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_n   = state;
    mask_n    = mask_q;
    ch_n      = cur_ch;
    col_n     = cur_col;
    drain_n   = drain_cnt;
    pending_n = pending;
    issue     = 1'b0;
    do_swap   = 1'b0;

    case (state)
      IDLE: begin
        // A held-over trigger is consumed here whether or not it starts a fetch.
        pending_n = 1'b0;
        if ((bus.trg || pending) && (bus.ch_mask != '0)) begin
          mask_n  = bus.ch_mask;
          ch_n    = first_ch;
          col_n   = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        issue = 1'b1;
        if (cur_col == COL_LAST) begin
          col_n = '0;
          if (nxt_found) begin
            ch_n = nxt_ch;
          end else begin
            state_n = DRAIN;
            drain_n = DC_W'(MEM_LAT - 1);
          end
        end else begin
          col_n = cur_col + 1'b1;
        end
      end
      DRAIN: begin
        // MEM_LAT cycles: the last tag leaves the latency pipe in the final one.
        if (drain_cnt == '0) state_n = WAIT_EOF;
        else                 drain_n = drain_cnt - 1'b1;
      end
      WAIT_EOF: begin
        if (bus.eof) begin
          do_swap = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if ((state != IDLE) && bus.trg) pending_n = 1'b1;

    if (!bus.en) begin
      state_n   = IDLE;
      pending_n = 1'b0;
      issue     = 1'b0;
      do_swap   = 1'b0;
    end
  end

  assign issue_idx = IW'(flat_idx(int'(cur_ch), int'(cur_col), N_COLS));

  rd_lat_pipe #(
    .LAT   (MEM_LAT),
    .IDX_W (IW)
  ) u_rd_lat_pipe (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .in_vld  (issue),
    .in_idx  (issue_idx),
    .out_vld (cap_vld),
    .out_idx (cap_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mask_q      <= '0;
      cur_ch      <= '0;
      cur_col     <= '0;
      drain_cnt   <= '0;
      pending     <= 1'b0;
      swap_done_q <= 1'b0;
      shadow      <= '0;
      active      <= '0;
    end else begin
      state       <= state_n;
      mask_q      <= mask_n;
      cur_ch      <= ch_n;
      cur_col     <= col_n;
      drain_cnt   <= drain_n;
      pending     <= pending_n;
      swap_done_q <= do_swap;
      if (do_swap) active <= shadow;
      // Captures still in flight when en drops are dropped, not written.
      if (cap_vld && bus.en) shadow[cap_idx] <= bus.mem_din;
    end
  end

  // Address held at the current (ch,col); equals BASE_ADDR after reset.
  assign bus.mem_addr  = BASE_ADDR + A_W'(flat_idx(int'(cur_ch), int'(cur_col), N_COLS));
  assign bus.mem_rd    = issue;
  assign bus.busy      = (state != IDLE);
  assign bus.swap_done = swap_done_q;
  assign bus.out       = active;

endmodule

// File: tb/tb_graph_col_buffer.sv
module tb_graph_col_buffer;
  import graph_pkg::*;

  localparam logic [12:0] BASE = 13'h0800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, trg, eof;
  logic [4:0] ch_mask;
  logic       use_const;
  logic [7:0] mem_xor;
  logic [7:0] d3_0, d3_1;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  graph_col_buffer_if #(.N_CH(5), .N_COLS(20), .D_W(8), .A_W(13)) if1 ();
  graph_col_buffer_if #(.N_CH(5), .N_COLS(20), .D_W(8), .A_W(13)) if3 ();

  graph_col_buffer #(
    .N_CH(5), .N_COLS(20), .D_W(8), .A_W(13), .BASE_ADDR(13'h0800), .MEM_LAT(1)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));

  graph_col_buffer #(
    .N_CH(5), .N_COLS(20), .D_W(8), .A_W(13), .BASE_ADDR(13'h0800), .MEM_LAT(3)
  ) u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if1.en = en;      assign if3.en = en;
  assign if1.trg = trg;    assign if3.trg = trg;
  assign if1.eof = eof;    assign if3.eof = eof;
  assign if1.ch_mask = ch_mask;
  assign if3.ch_mask = ch_mask;

  function automatic logic [7:0] mem_val(input logic [12:0] a);
    return use_const ? 8'hAA : (a[7:0] ^ mem_xor);
  endfunction

  // Memories: 1-cycle and 3-cycle read latency.
  always @(posedge clk) begin
    if1.mem_din <= mem_val(if1.mem_addr);
    d3_0        <= mem_val(if3.mem_addr);
    d3_1        <= d3_0;
    if3.mem_din <= d3_1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Observation: issued addresses, issue span, WAIT_EOF entry, swap pulses.
  logic [12:0] q1[$], q3[$];
  int first1, last1, first3, last3, w1, w3, sd1, sd3;
  gcb_state_t p1 = IDLE, p3 = IDLE;

  always @(negedge clk) begin
    if (if1.mem_rd) begin
      if (q1.size() == 0) first1 = cyc;
      q1.push_back(if1.mem_addr);
      last1 = cyc;
    end
    if (if3.mem_rd) begin
      if (q3.size() == 0) first3 = cyc;
      q3.push_back(if3.mem_addr);
      last3 = cyc;
    end
    if (u1.state == WAIT_EOF && p1 != WAIT_EOF) w1 = cyc;
    if (u3.state == WAIT_EOF && p3 != WAIT_EOF) w3 = cyc;
    p1 = u1.state;
    p3 = u3.state;
    if (if1.swap_done) sd1++;
    if (if3.swap_done) sd3++;
  end

  // Reference model: shadow/active as plain arrays of column heights.
  logic [7:0] sh_m[100];
  logic [7:0] act_m[100];

  task automatic model_fetch(input logic [4:0] m);
    for (int ch = 0; ch < 5; ch++)
      if (m[ch])
        for (int col = 0; col < 20; col++)
          sh_m[ch*20+col] = mem_val(BASE + 13'(ch*20 + col));
  endtask

  task automatic model_swap();
    for (int k = 0; k < 100; k++) act_m[k] = sh_m[k];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 100; k++) begin
      sh_m[k]  = 8'h00;
      act_m[k] = 8'h00;
    end
  endtask

  function automatic logic [799:0] act_flat();
    logic [799:0] v;
    for (int k = 0; k < 100; k++) v[k*8 +: 8] = act_m[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [799:0] obs, input logic [799:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issues(input string tag, input logic [12:0] q[$], input logic [4:0] m);
    logic [12:0] e[$];
    int bad;
    bad = -1;
    for (int ch = 0; ch < 5; ch++)
      if (m[ch])
        for (int col = 0; col < 20; col++) e.push_back(BASE + 13'(ch*20 + col));
    for (int i = 0; i < e.size(); i++)
      if (i < q.size() && bad < 0 && q[i] !== e[i]) bad = i;
    n_vec++;
    assert (q.size() == e.size() && bad < 0)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d issues (first wrong index %0d) expected %0d issues",
             tag, q.size(), bad, e.size());
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    q1.delete();
    q3.delete();
    sd1 = 0;
    sd3 = 0;
  endtask

  // Trigger a fetch and wait until both instances sit in WAIT_EOF.
  task automatic run_fetch(input logic [4:0] m);
    ch_mask = m;
    trg = 1'b1;
    tick();
    trg = 1'b0;
    tick(109);
    model_fetch(m);
  endtask

  task automatic pulse_eof();
    eof = 1'b1;
    tick();
    eof = 1'b0;
  endtask

  function automatic logic [12:0] first_addr(input logic [4:0] m);
    for (int ch = 0; ch < 5; ch++)
      if (m[ch]) return BASE + 13'(ch*20);
    return BASE;
  endfunction

  logic [4:0] m, m2;

  initial begin
    rst = 1'b1; en = 1'b0; trg = 1'b0; eof = 1'b0; ch_mask = '0;
    use_const = 1'b0; mem_xor = 8'h00;
    model_reset();
    tick(3);

    // Reset state
    chk("rst_out1", if1.out, act_flat());
    chk("rst_out3", if3.out, act_flat());
    chk("rst_busy", {if1.busy, if3.busy}, 2'b00);
    chk("rst_rd", {if1.mem_rd, if3.mem_rd}, 2'b00);
    chk("rst_sd", {if1.swap_done, if3.swap_done}, 2'b00);
    chk("rst_addr1", if1.mem_addr, BASE);
    chk("rst_addr3", if3.mem_addr, BASE);
    rst = 1'b0;
    en = 1'b1;
    tick();

    // Trigger with an empty mask is ignored
    ch_mask = 5'b00000;
    trg = 1'b1;
    tick();
    trg = 1'b0;
    chk("mask0_busy", {if1.busy, if3.busy}, 2'b00);
    chk("mask0_rd", {if1.mem_rd, if3.mem_rd}, 2'b00);

    // Full fetch: memory[a] = a[7:0]
    clear_obs();
    ch_mask = 5'b11111;
    trg = 1'b1;
    tick();
    trg = 1'b0;
    chk("first_issue1", {if1.mem_rd, if1.mem_addr}, {1'b1, BASE});
    chk("first_issue3", {if3.mem_rd, if3.mem_addr}, {1'b1, BASE});
    tick(108);
    model_fetch(5'b11111);
    chk_issues("full_addrs1", q1, 5'b11111);
    chk_issues("full_addrs3", q3, 5'b11111);
    chk("full_consec1", last1 - first1, 99);
    chk("full_wait_entry1", w1 - last1, 2);
    chk("full_hold_out1", if1.out, act_flat());
    pulse_eof();
    model_swap();
    chk("full_sd1", if1.swap_done, 1'b1);
    chk("full_busy_low", {if1.busy, if3.busy}, 2'b00);
    chk("full_out1", if1.out, act_flat());
    chk("full_out3", if3.out, act_flat());
    chk("full_elem_2_7", if1.out[(2*20+7)*8 +: 8], 8'h2F);
    tick();
    chk("full_sd_end", {if1.swap_done, if3.swap_done}, 2'b00);
    tick(2);
    chk("full_sd_count", {sd1[7:0], sd3[7:0]}, {8'd1, 8'd1});

    // Prefill active with 0xAA, then fetch channels 0 and 2 only
    use_const = 1'b1;
    run_fetch(5'b11111);
    pulse_eof();
    model_swap();
    chk("prefill_out1", if1.out, act_flat());
    use_const = 1'b0;
    clear_obs();
    run_fetch(5'b00101);
    chk_issues("skip_addrs1", q1, 5'b00101);
    chk_issues("skip_addrs3", q3, 5'b00101);
    pulse_eof();
    model_swap();
    chk("skip_out1", if1.out, act_flat());
    chk("skip_out3", if3.out, act_flat());
    chk("skip_ch1_kept", if1.out[(1*20+0)*8 +: 8], 8'hAA);
    chk("skip_ch4_kept", if3.out[(4*20+19)*8 +: 8], 8'hAA);

    // Latency: memory[a] = ~a[7:0]
    mem_xor = 8'hFF;
    clear_obs();
    run_fetch(5'b11111);
    chk("lat_wait_entry3", w3 - last3, 4);
    chk("lat_consec3", last3 - first3, 99);
    pulse_eof();
    model_swap();
    chk("lat_out3", if3.out, act_flat());
    chk("lat_out1", if1.out, act_flat());

    // Tear-free: eof during FETCH is ignored
    mem_xor = 8'($urandom);
    ch_mask = 5'b11111;
    trg = 1'b1;
    tick();
    trg = 1'b0;
    tick(30);
    pulse_eof();
    chk("tear_sd", {if1.swap_done, if3.swap_done}, 2'b00);
    chk("tear_out1", if1.out, act_flat());
    tick(79);
    chk("tear_busy", {if1.busy, if3.busy}, 2'b11);
    chk("tear_out3", if3.out, act_flat());
    model_fetch(5'b11111);
    pulse_eof();
    model_swap();
    chk("tear_swap_out1", if1.out, act_flat());
    chk("tear_swap_out3", if3.out, act_flat());

    // Pending: two triggers during FETCH give exactly one extra fetch
    m  = 5'($urandom_range(31, 1));
    m2 = 5'($urandom_range(31, 1));
    mem_xor = 8'($urandom);
    ch_mask = m;
    trg = 1'b1;
    tick();
    trg = 1'b0;
    tick(10);
    trg = 1'b1;
    tick();
    trg = 1'b0;
    tick(5);
    trg = 1'b1;
    tick();
    trg = 1'b0;
    tick(95);
    model_fetch(m);
    clear_obs();
    ch_mask = m2;
    pulse_eof();
    model_swap();
    chk("pend_sd", {if1.swap_done, if3.swap_done}, 2'b11);
    chk("pend_idle_gap", {if1.busy, if3.busy}, 2'b00);
    tick();
    chk("pend_restart1", {if1.busy, if1.mem_rd, if1.mem_addr}, {2'b11, first_addr(m2)});
    chk("pend_restart3", {if3.busy, if3.mem_rd, if3.mem_addr}, {2'b11, first_addr(m2)});
    tick(110);
    chk_issues("pend_addrs1", q1, m2);
    chk_issues("pend_addrs3", q3, m2);
    model_fetch(m2);
    pulse_eof();
    model_swap();
    chk("pend_out1", if1.out, act_flat());
    chk("pend_out3", if3.out, act_flat());
    clear_obs();
    tick(5);
    chk("pend_no_second", {if1.busy, if3.busy, 8'(q1.size()), 8'(q3.size())}, 18'd0);

    // Abort: drop en mid-FETCH
    ch_mask = 5'b11111;
    trg = 1'b1;
    tick();
    trg = 1'b0;
    tick(20);
    en = 1'b0;
    tick();
    chk("abort_busy", {if1.busy, if3.busy}, 2'b00);
    chk("abort_rd", {if1.mem_rd, if3.mem_rd}, 2'b00);
    chk("abort_out1", if1.out, act_flat());
    en = 1'b1;
    tick(3);
    chk("abort_out3", if3.out, act_flat());
    chk("abort_stay_idle", {if1.busy, if3.busy}, 2'b00);
    // Full refresh so the shadow contents are fully known again
    mem_xor = 8'($urandom);
    run_fetch(5'b11111);
    pulse_eof();
    model_swap();
    chk("refresh_out1", if1.out, act_flat());

    // Random masks and memory contents
    for (int it = 0; it < 4; it++) begin
      m = 5'($urandom_range(31, 1));
      mem_xor = 8'($urandom);
      clear_obs();
      run_fetch(m);
      chk_issues($sformatf("rnd%0d_addrs1", it), q1, m);
      chk_issues($sformatf("rnd%0d_addrs3", it), q3, m);
      pulse_eof();
      model_swap();
      chk($sformatf("rnd%0d_sd", it), {if1.swap_done, if3.swap_done}, 2'b11);
      chk($sformatf("rnd%0d_out1", it), if1.out, act_flat());
      chk($sformatf("rnd%0d_out3", it), if3.out, act_flat());
    end

    // Reset mid-operation (DRAIN)
    ch_mask = 5'b11111;
    trg = 1'b1;
    tick();
    trg = 1'b0;
    tick(100);
    chk("mid_drain_state1", u1.state, DRAIN);
    chk("mid_drain_state3", u3.state, DRAIN);
    rst = 1'b1;
    tick();
    model_reset();
    chk("mid_rst_out1", if1.out, act_flat());
    chk("mid_rst_out3", if3.out, act_flat());
    chk("mid_rst_busy", {if1.busy, if3.busy, if1.mem_rd, if3.mem_rd}, 4'b0000);
    chk("mid_rst_addr", {if1.mem_addr, if3.mem_addr}, {BASE, BASE});
    chk("mid_rst_state", {u1.state, u3.state}, {IDLE, IDLE});
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
